// File: rtl/rptr_status_handler.sv
// Read-side pointer handler for an async FIFO: binary/Gray read pointers,
// registered empty/almost_empty, read-side occupancy, read ack and sticky underflow.
module rptr_status_handler #(
  parameter int PTR_WIDTH     = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] g_wptr_sync,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] rd_count,
  output logic               rd_ack,
  output logic               underflow
);

  localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH+1)'(AEMPTY_THRESH);

  logic [PTR_WIDTH:0] r_b_rptr, r_g_rptr, r_rd_count;
  logic               r_empty, r_almost_empty, r_rd_ack, r_underflow;

  logic               w_rd_fire;
  logic [PTR_WIDTH:0] w_b_rptr_next, w_g_rptr_next, w_b_wptr_sync, w_occ;

  // Fire only against the registered empty so r_en never reaches an output combinationally.
  assign w_rd_fire     = r_en & ~r_empty;
  assign w_b_rptr_next = r_b_rptr + {{PTR_WIDTH{1'b0}}, w_rd_fire};
  assign w_g_rptr_next = (w_b_rptr_next >> 1) ^ w_b_rptr_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_b_wptr_sync = '0;
    for (int i = 0; i <= PTR_WIDTH; i++)
      w_b_wptr_sync[i] = ^(g_wptr_sync >> i);
  end

  assign w_occ = w_b_wptr_sync - w_b_rptr_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_rd_count     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_ack       <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_rptr_next;
      r_g_rptr       <= w_g_rptr_next;
      r_rd_count     <= w_occ;
      r_empty        <= (w_g_rptr_next == g_wptr_sync);
      r_almost_empty <= (w_occ <= AE_THRESH);
      r_rd_ack       <= w_rd_fire;
      r_underflow    <= r_underflow | (r_en & r_empty);
    end
  end

  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_count     = r_rd_count;
  assign rd_ack       = r_rd_ack;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_rptr_status_handler.sv
// Directed bench for rptr_status_handler (PTR_WIDTH=3, AEMPTY_THRESH=1).
module tb_rptr_status_handler;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       r_en;
  logic [3:0] g_wptr_sync;
  logic [3:0] b_rptr, g_rptr, rd_count;
  logic       empty, almost_empty, rd_ack, underflow;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] wb;
  logic [3:0] g_prev = '0;
  bit         chk_gray = 1'b0;

  rptr_status_handler #(.PTR_WIDTH(3), .AEMPTY_THRESH(1)) dut (
    .rclk(rclk), .rrst(rrst), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
    .b_rptr(b_rptr), .g_rptr(g_rptr), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .rd_ack(rd_ack), .underflow(underflow)
  );

  always #5 rclk = ~rclk;

  // Synchronized Gray write pointer may move at most one bit per rclk.
  always @(posedge rclk) begin
    if (chk_gray) begin
      n_cmp++;
      if ($countones(g_wptr_sync ^ g_prev) > 1) begin
        n_err++;
        $display("FAIL gray_step prev=%b now=%b (must differ in <=1 bit)", g_prev, g_wptr_sync);
      end
    end
    g_prev <= g_wptr_sync;
  end

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    chk_gray = 1'b0;
    rrst = 1'b1; r_en = 1'b0; wb = 4'd0; g_wptr_sync = 4'd0;
    step();
    rrst = 1'b0;
    step();
    chk_gray = 1'b1;
  endtask

  task automatic wr_to(input logic [3:0] target);
    r_en = 1'b0;
    while (wb != target) begin
      wb = wb + 4'd1;
      g_wptr_sync = bin2gray(wb);
      step();
    end
  endtask

  task automatic test_reset();
    chk_gray = 1'b0;
    n_cmp++; if ({b_rptr, g_rptr, rd_count} !== 12'h000) begin n_err++;
      $display("FAIL rst_ptrs got %h want 000", {b_rptr, g_rptr, rd_count}); end
    n_cmp++; if ({empty, almost_empty, rd_ack, underflow} !== 4'b1100) begin n_err++;
      $display("FAIL rst_flags got %b want 1100", {empty, almost_empty, rd_ack, underflow}); end
    rrst = 1'b0; r_en = 1'b1; g_wptr_sync = 4'b0011;
    step();
    n_cmp++; if ({empty, rd_count, underflow} !== {1'b0, 4'd2, 1'b1}) begin n_err++;
      $display("FAIL rst_pre1 got e=%b cnt=%0d uf=%b want e=0 cnt=2 uf=1", empty, rd_count, underflow); end
    step();
    n_cmp++; if ({b_rptr, g_rptr, rd_ack} !== {4'd1, 4'b0001, 1'b1}) begin n_err++;
      $display("FAIL rst_pre2 got b=%h g=%b ack=%b want b=1 g=0001 ack=1", b_rptr, g_rptr, rd_ack); end
    #2 rrst = 1'b1;
    #1;
    n_cmp++; if ({b_rptr, g_rptr, rd_count} !== 12'h000) begin n_err++;
      $display("FAIL rst_async_ptrs got %h want 000", {b_rptr, g_rptr, rd_count}); end
    n_cmp++; if ({empty, almost_empty, rd_ack, underflow} !== 4'b1100) begin n_err++;
      $display("FAIL rst_async_flags got %b want 1100", {empty, almost_empty, rd_ack, underflow}); end
    step();
    n_cmp++; if ({b_rptr, empty, underflow} !== {4'd0, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL rst_hold got b=%h e=%b uf=%b want b=0 e=1 uf=0", b_rptr, empty, underflow); end
    r_en = 1'b0; g_wptr_sync = 4'd0; wb = 4'd0;
    rrst = 1'b0;
    step();
    n_cmp++; if ({empty, almost_empty, rd_count} !== {1'b1, 1'b1, 4'd0}) begin n_err++;
      $display("FAIL rst_release got e=%b ae=%b cnt=%0d want 1 1 0", empty, almost_empty, rd_count); end
    chk_gray = 1'b1;
  endtask

  task automatic test_single_word();
    wb = 4'd1; g_wptr_sync = 4'b0001;
    step();
    n_cmp++; if ({empty, rd_count, almost_empty} !== {1'b0, 4'd1, 1'b1}) begin n_err++;
      $display("FAIL sw_arrive got e=%b cnt=%0d ae=%b want 0 1 1", empty, rd_count, almost_empty); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    n_cmp++; if ({b_rptr, g_rptr} !== {4'd1, 4'b0001}) begin n_err++;
      $display("FAIL sw_ptr got b=%h g=%b want b=1 g=0001", b_rptr, g_rptr); end
    n_cmp++; if ({empty, rd_count, rd_ack} !== {1'b1, 4'd0, 1'b1}) begin n_err++;
      $display("FAIL sw_read got e=%b cnt=%0d ack=%b want 1 0 1", empty, rd_count, rd_ack); end
    step();
    n_cmp++; if ({rd_ack, b_rptr} !== {1'b0, 4'd1}) begin n_err++;
      $display("FAIL sw_ack_pulse got ack=%b b=%h want ack=0 b=1", rd_ack, b_rptr); end
  endtask

  task automatic test_full_drain();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      wb = 4'(k); g_wptr_sync = bin2gray(wb);
      step();
      n_cmp++; if ({rd_count, almost_empty, empty} !== {4'(k), (k <= 1), 1'b0}) begin n_err++;
        $display("FAIL fd_fill%0d got cnt=%0d ae=%b e=%b want cnt=%0d ae=%b e=0",
                 k, rd_count, almost_empty, empty, k, (k <= 1)); end
    end
    r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++; if ({b_rptr, rd_count, almost_empty, empty, rd_ack} !==
                   {4'(i), 4'(8 - i), ((8 - i) <= 1), (i == 8), 1'b1}) begin n_err++;
        $display("FAIL fd_read%0d got b=%0d cnt=%0d ae=%b e=%b ack=%b want b=%0d cnt=%0d ae=%b e=%b ack=1",
                 i, b_rptr, rd_count, almost_empty, empty, rd_ack, i, 8 - i, ((8 - i) <= 1), (i == 8)); end
    end
    r_en = 1'b0;
    n_cmp++; if ({b_rptr, g_rptr} !== {4'b1000, 4'b1100}) begin n_err++;
      $display("FAIL fd_end got b=%b g=%b want 1000 1100", b_rptr, g_rptr); end
  endtask

  task automatic test_wrap();
    wr_to(4'd14);
    r_en = 1'b1;
    repeat (6) step();
    r_en = 1'b0;
    n_cmp++; if ({b_rptr, empty} !== {4'd14, 1'b1}) begin n_err++;
      $display("FAIL wr_setup got b=%0d e=%b want b=14 e=1", b_rptr, empty); end
    wr_to(4'd2);
    n_cmp++; if ({rd_count, almost_empty, empty} !== {4'd4, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL wr_count got cnt=%0d ae=%b e=%b want 4 0 0", rd_count, almost_empty, empty); end
    r_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if ({b_rptr, rd_count} !== {4'(14 + i), 4'(4 - i)}) begin n_err++;
        $display("FAIL wr_read%0d got b=%0d cnt=%0d want b=%0d cnt=%0d",
                 i, b_rptr, rd_count, 4'(14 + i), 4 - i); end
    end
    r_en = 1'b0;
    n_cmp++; if ({g_rptr, empty} !== {4'b0011, 1'b1}) begin n_err++;
      $display("FAIL wr_end got g=%b e=%b want 0011 1", g_rptr, empty); end
  endtask

  task automatic test_underflow();
    n_cmp++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL uf_clear got %b want 0", underflow); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    n_cmp++; if ({b_rptr, g_rptr, rd_ack, underflow, empty} !== {4'd2, 4'b0011, 1'b0, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL uf_blocked got b=%0d g=%b ack=%b uf=%b e=%b want 2 0011 0 1 1",
               b_rptr, g_rptr, rd_ack, underflow, empty); end
    wb = 4'd3; g_wptr_sync = bin2gray(wb);
    step();
    n_cmp++; if ({empty, rd_count, underflow} !== {1'b0, 4'd1, 1'b1}) begin n_err++;
      $display("FAIL uf_sticky got e=%b cnt=%0d uf=%b want 0 1 1", empty, rd_count, underflow); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    n_cmp++; if ({b_rptr, rd_ack, underflow} !== {4'd3, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL uf_read got b=%0d ack=%b uf=%b want 3 1 1", b_rptr, rd_ack, underflow); end
    do_reset();
    n_cmp++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL uf_rst got %b want 0", underflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wb = 4'd1; g_wptr_sync = bin2gray(wb);
    step();
    r_en = 1'b1;
    wb = 4'd2; g_wptr_sync = bin2gray(wb);
    step();
    r_en = 1'b0;
    n_cmp++; if ({empty, rd_count, rd_ack, b_rptr} !== {1'b0, 4'd1, 1'b1, 4'd1}) begin n_err++;
      $display("FAIL sim_edge got e=%b cnt=%0d ack=%b b=%0d want 0 1 1 1", empty, rd_count, rd_ack, b_rptr); end
    step();
    n_cmp++; if ({empty, rd_count, rd_ack} !== {1'b0, 4'd1, 1'b0}) begin n_err++;
      $display("FAIL sim_after got e=%b cnt=%0d ack=%b want 0 1 0", empty, rd_count, rd_ack); end
  endtask

  initial begin
    rrst = 1'b1; r_en = 1'b0; g_wptr_sync = 4'd0; wb = 4'd0;
    repeat (2) step();
    test_reset();
    test_single_word();
    test_full_drain();
    test_wrap();
    test_underflow();
    test_simultaneous();
    chk_gray = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rptr_status_handler.md
Name: rptr_status_handler

Overview:
Read-side pointer handler for the asynchronous FIFO. It mirrors the write-side pointer handler in the read clock domain and extends it with status outputs.
- Advances the binary and Gray read pointers on accepted reads.
- Generates registered empty / almost_empty.
- Computes read-side occupancy from the synchronized Gray write pointer.
- Flags underflow attempts.
It sits between the read port and the FIFO memory / 2-FF write-pointer synchronizer.

Parameters:
PTR_WIDTH, 3, pointer address width; FIFO depth = 2**PTR_WIDTH; pointers carry one extra wrap bit.
AEMPTY_THRESH, 1, almost_empty asserts when occupancy <= this value (legal range 0..2**PTR_WIDTH-1).

Ports:
rclk  input  1  read-domain clock, all state on rising edge
rrst  input  1  asynchronous, active-high reset
r_en  input  1  read request
g_wptr_sync  input  PTR_WIDTH+1  Gray write pointer, already synchronized into rclk
b_rptr  output  PTR_WIDTH+1  binary read pointer (low PTR_WIDTH bits address memory)
g_rptr  output  PTR_WIDTH+1  Gray read pointer, to write-domain synchronizer
empty  output  1  registered empty flag
almost_empty  output  1  registered occupancy <= AEMPTY_THRESH
rd_count  output  PTR_WIDTH+1  registered occupancy, 0..2**PTR_WIDTH
rd_ack  output  1  one-cycle pulse, read accepted on previous edge
underflow  output  1  sticky, read attempted while empty

Behaviour:
- Reset (rrst high, asynchronous, any time including mid-read):
  - b_rptr=0, g_rptr=0, rd_count=0, rd_ack=0, underflow=0.
  - empty=1, almost_empty=1.
  - Outputs hold these values while rrst is high.
  - First update occurs on the first rclk edge after rrst deasserts.
- Accept condition:
  - rd_fire = r_en & ~empty, using the registered empty.
  - b_rptr_next = b_rptr + rd_fire, modulo 2**(PTR_WIDTH+1); wraps naturally from all-ones to 0.
  - g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next.
  - b_rptr and g_rptr load b_rptr_next and g_rptr_next every edge; both update together, with zero latency from the accepting edge.
- Empty:
  - empty <= (g_rptr_next == g_wptr_sync), registered.
  - Reading the last word deasserts nothing extra: empty rises on the same edge the pointer advances.
- Occupancy:
  - b_wptr_sync = Gray-to-binary of g_wptr_sync, combinational: bit[MSB] = g[MSB]; bit[i] = bit[i+1] ^ g[i].
  - rd_count <= (b_wptr_sync - b_rptr_next), modulo 2**(PTR_WIDTH+1).
  - almost_empty <= (that same value <= AEMPTY_THRESH).
  - rd_count is pessimistic (never overstates data), because of synchronizer lag.
- rd_ack: rd_ack <= rd_fire.
- underflow:
  - Set on any edge where r_en & empty.
  - Stays 1 until rrst.
  - A blocked read never moves the pointers.
- Simultaneous write-pointer advance and last-word read on the same edge: use the current g_wptr_sync; empty stays 0 if they differ after the read.
- g_wptr_sync is trusted to change by at most one Gray step per rclk; multi-bit jumps are out of scope, and the bench asserts on them.
- No combinational path from r_en to any output.

Test Plan (PTR_WIDTH=3, AEMPTY_THRESH=1):
1. Reset: drive r_en=1 and g_wptr_sync=4'b0011, then pulse rrst mid-cycle -> outputs go to 0/0/empty=1/almost_empty=1/rd_count=0/underflow=0 immediately, without waiting for an rclk edge.
2. Single word: from reset, g_wptr_sync 0->4'b0001 with r_en=0.
   - Next edge: empty=0, rd_count=1, almost_empty=1.
   - Then r_en=1 for one cycle: b_rptr=1, g_rptr=4'b0001, empty=1, rd_count=0, rd_ack=1 for exactly one cycle.
3. Full drain: g_wptr_sync=4'b1100 (binary 8).
   - Result: rd_count=8, almost_empty=0.
   - Eight back-to-back reads: rd_count 7..0, almost_empty rises when rd_count=1.
   - After the eighth read: b_rptr=4'b1000, g_rptr=4'b1100, empty=1.
4. Wrap-around: start from b_rptr=14 with g_wptr_sync=4'b0011 (binary 2) -> rd_count=4. Four reads -> b_rptr 15,0,1,2; g_rptr ends 4'b0011; empty=1.
5. Underflow: r_en=1 while empty=1 -> b_rptr and g_rptr unchanged, rd_ack=0, underflow=1 and stays 1 after data arrives, until rrst.
6. Simultaneous: one word present and r_en=1, while g_wptr_sync advances by one on the same edge -> empty stays 0, rd_count stays 1, rd_ack=1.
